// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions: packet data types, frame controller states and
// the byte-qualifier helper used on the pixel stream.
package csi2_pkg;

    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LS       = 6'h02;
    localparam logic [5:0] DT_LE       = 6'h03;
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        LONG  = 2'd2,
        DROP  = 2'd3
    } frame_state_t;

    // Valid-byte mask for a 32-bit beat given the payload bytes still owed.
    function automatic logic [3:0] keep_mask(input logic [15:0] remaining);
        logic [3:0] mask;
        if (remaining >= 16'd4) begin
            mask = 4'hF;
        end else begin
            case (remaining[1:0])
                2'd1:    mask = 4'h1;
                2'd2:    mask = 4'h3;
                2'd3:    mask = 4'h7;
                default: mask = 4'h0;
            endcase
        end
        return mask;
    endfunction

endpackage

// File: rtl/csi2_frame_controller_if.sv
// Packet-in / pixel-and-event-out bundle between the CSI-2 receiver and the
// frame controller; master is the controller side.
interface csi2_frame_controller_if #(
    parameter int LINE_W = 12
) ();
    logic [1:0]        virtual_channel;
    logic [15:0]       word_count;
    logic [5:0]        image_data_type;
    logic [31:0]       image_data;
    logic              image_data_enable;
    logic              interrupt;

    logic              frame_active;
    logic              frame_start;
    logic              frame_end;
    logic [15:0]       frame_number;
    logic [LINE_W-1:0] line_count;
    logic [31:0]       pixel_data;
    logic [3:0]        pixel_keep;
    logic              pixel_valid;
    logic              pixel_last;
    logic [5:0]        pixel_data_type;
    logic              err_protocol;
    logic              err_length;

    modport master (
        input  virtual_channel, word_count, image_data_type, image_data,
               image_data_enable, interrupt,
        output frame_active, frame_start, frame_end, frame_number, line_count,
               pixel_data, pixel_keep, pixel_valid, pixel_last, pixel_data_type,
               err_protocol, err_length
    );

    modport slave (
        output virtual_channel, word_count, image_data_type, image_data,
               image_data_enable, interrupt,
        input  frame_active, frame_start, frame_end, frame_number, line_count,
               pixel_data, pixel_keep, pixel_valid, pixel_last, pixel_data_type,
               err_protocol, err_length
    );
endinterface

// File: rtl/csi2_frame_controller.sv
// Turns the parsed CSI-2 packet stream into frame/line events and a
// byte-qualified pixel stream, flagging sequence and length errors.
module csi2_frame_controller
    import csi2_pkg::*;
#(
    parameter logic [1:0] VC_SELECT     = 2'd0,
    parameter bit         ACCEPT_ALL_VC = 1'b0,
    parameter int         LINE_W        = 12
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    csi2_frame_controller_if.master bus
);

    function automatic logic [LINE_W-1:0] sat_inc(input logic [LINE_W-1:0] v);
        return (&v) ? v : v + LINE_W'(1);
    endfunction

    frame_state_t      r_state;
    logic              r_irq;
    logic              r_ignore;
    logic [15:0]       r_remaining;
    logic              r_frame_active;
    logic              r_frame_start;
    logic              r_frame_end;
    logic [15:0]       r_frame_number;
    logic [LINE_W-1:0] r_line_count;
    logic [31:0]       r_pixel_data;
    logic [3:0]        r_pixel_keep;
    logic              r_pixel_valid;
    logic              r_pixel_last;
    logic [5:0]        r_pixel_data_type;
    logic              r_err_protocol;
    logic              r_err_length;

    logic              w_hdr;
    logic              w_end;
    logic              w_vc_ok;
    logic              w_beat;
    logic [15:0]       w_take;
    logic [15:0]       w_rem_next;

    assign w_hdr      = bus.interrupt & ~r_irq;
    assign w_end      = ~bus.interrupt & r_irq;
    assign w_vc_ok    = ACCEPT_ALL_VC || (bus.virtual_channel == VC_SELECT);
    assign w_beat     = (r_state == LONG) && bus.image_data_enable && !r_ignore;
    assign w_take     = (r_remaining >= 16'd4) ? 16'd4 : r_remaining;
    assign w_rem_next = w_beat ? (r_remaining - w_take) : r_remaining;

    // r_irq resets high so an interrupt still asserted across reset release
    // is not mistaken for a fresh header; a spurious end in IDLE is harmless.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state           <= IDLE;
            r_irq             <= 1'b1;
            r_ignore          <= 1'b0;
            r_remaining       <= '0;
            r_frame_active    <= 1'b0;
            r_frame_start     <= 1'b0;
            r_frame_end       <= 1'b0;
            r_frame_number    <= '0;
            r_line_count      <= '0;
            r_pixel_data      <= '0;
            r_pixel_keep      <= '0;
            r_pixel_valid     <= 1'b0;
            r_pixel_last      <= 1'b0;
            r_pixel_data_type <= '0;
            r_err_protocol    <= 1'b0;
            r_err_length      <= 1'b0;
        end else begin
            r_irq          <= bus.interrupt;
            r_frame_start  <= 1'b0;
            r_frame_end    <= 1'b0;
            r_err_protocol <= 1'b0;
            r_err_length   <= 1'b0;
            r_pixel_valid  <= 1'b0;
            r_pixel_last   <= 1'b0;

            if (w_beat) begin
                r_remaining <= w_rem_next;
                if (r_remaining == 16'd0) begin
                    r_err_length <= 1'b1;
                end else begin
                    r_pixel_valid <= 1'b1;
                    r_pixel_data  <= bus.image_data;
                    r_pixel_keep  <= keep_mask(r_remaining);
                    r_pixel_last  <= (w_rem_next == 16'd0);
                end
            end

            // Packet end takes priority over a header in the same cycle.
            if (w_end) begin
                r_ignore <= 1'b0;
                if (!r_ignore) begin
                    case (r_state)
                        LONG: begin
                            if (w_rem_next != 16'd0) r_err_length <= 1'b1;
                            r_line_count <= sat_inc(r_line_count);
                            r_state      <= FRAME;
                        end
                        DROP:    r_state <= IDLE;
                        default: ;
                    endcase
                end
            end else if (w_hdr) begin
                if (!w_vc_ok) begin
                    r_ignore <= 1'b1;
                end else if (bus.image_data_type == DT_FS) begin
                    if (r_state == FRAME) r_err_protocol <= 1'b1;
                    r_state        <= FRAME;
                    r_frame_active <= 1'b1;
                    r_frame_start  <= 1'b1;
                    r_frame_number <= bus.word_count;
                    r_line_count   <= '0;
                end else if (bus.image_data_type == DT_FE) begin
                    if (r_state == FRAME) begin
                        r_state        <= IDLE;
                        r_frame_active <= 1'b0;
                        r_frame_end    <= 1'b1;
                        if (bus.word_count != r_frame_number) r_err_protocol <= 1'b1;
                    end else begin
                        r_err_protocol <= 1'b1;
                    end
                end else if (bus.image_data_type >= DT_LONG_MIN) begin
                    if (r_state == FRAME) begin
                        r_state           <= LONG;
                        r_remaining       <= bus.word_count;
                        r_pixel_data_type <= bus.image_data_type;
                    end else begin
                        r_state        <= DROP;
                        r_err_protocol <= 1'b1;
                    end
                end else if ((bus.image_data_type == DT_LS) || (bus.image_data_type == DT_LE)) begin
                    if (r_state != FRAME) r_err_protocol <= 1'b1;
                end
            end
        end
    end

    assign bus.frame_active    = r_frame_active;
    assign bus.frame_start     = r_frame_start;
    assign bus.frame_end       = r_frame_end;
    assign bus.frame_number    = r_frame_number;
    assign bus.line_count      = r_line_count;
    assign bus.pixel_data      = r_pixel_data;
    assign bus.pixel_keep      = r_pixel_keep;
    assign bus.pixel_valid     = r_pixel_valid;
    assign bus.pixel_last      = r_pixel_last;
    assign bus.pixel_data_type = r_pixel_data_type;
    assign bus.err_protocol    = r_err_protocol;
    assign bus.err_length      = r_err_length;

endmodule

// File: tb/tb_csi2_frame_controller.sv
// Bench for csi2_frame_controller: a VC-filtered instance and an accept-all
// instance share one stimulus stream and are checked against a packet-level model.
module tb_csi2_frame_controller;
    import csi2_pkg::*;

    localparam int LW       = 3;
    localparam int LINE_MAX = (1 << LW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csi2_frame_controller_if #(.LINE_W(LW)) bus0 ();
    csi2_frame_controller_if #(.LINE_W(LW)) bus1 ();

    csi2_frame_controller #(.VC_SELECT(2'd0), .ACCEPT_ALL_VC(1'b0), .LINE_W(LW)) dut0 (
        .i_clock(clk), .i_reset_n(rst_n), .bus(bus0.master));
    csi2_frame_controller #(.VC_SELECT(2'd0), .ACCEPT_ALL_VC(1'b1), .LINE_W(LW)) dut1 (
        .i_clock(clk), .i_reset_n(rst_n), .bus(bus1.master));

    typedef struct {
        logic          fa, fs, fe;
        logic [15:0]   fn;
        logic [LW-1:0] lc;
        logic [31:0]   pd;
        logic [3:0]    pk;
        logic          pv, pl;
        logic [5:0]    pdt;
        logic          ep, el;
    } obs_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Packet-level reference state, one slot per instance.
    bit          m_in_frame [2];
    logic [15:0] m_fnum     [2];
    int          m_lines    [2];
    bit          m_long     [2];
    int          m_rem      [2];
    logic [5:0]  m_pdt      [2];
    bit          m_ign      [2];

    bit          e_fs, e_fe, e_ep, e_el, e_pv, e_pl;
    logic [31:0] e_pd;
    logic [3:0]  e_pk;

    logic [31:0] pay[$];
    logic [15:0] last_fs_wc = 16'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic obs_t get_obs(input int k);
        obs_t o;
        if (k == 0) begin
            o.fa = bus0.frame_active; o.fs = bus0.frame_start; o.fe = bus0.frame_end;
            o.fn = bus0.frame_number; o.lc = bus0.line_count;  o.pd = bus0.pixel_data;
            o.pk = bus0.pixel_keep;   o.pv = bus0.pixel_valid; o.pl = bus0.pixel_last;
            o.pdt = bus0.pixel_data_type; o.ep = bus0.err_protocol; o.el = bus0.err_length;
        end else begin
            o.fa = bus1.frame_active; o.fs = bus1.frame_start; o.fe = bus1.frame_end;
            o.fn = bus1.frame_number; o.lc = bus1.line_count;  o.pd = bus1.pixel_data;
            o.pk = bus1.pixel_keep;   o.pv = bus1.pixel_valid; o.pl = bus1.pixel_last;
            o.pdt = bus1.pixel_data_type; o.ep = bus1.err_protocol; o.el = bus1.err_length;
        end
        return o;
    endfunction

    task automatic drive(input logic irq, input logic [1:0] vc, input logic [15:0] wc,
                         input logic [5:0] dt, input logic [31:0] d, input logic en);
        bus0.interrupt = irq; bus0.virtual_channel = vc; bus0.word_count = wc;
        bus0.image_data_type = dt; bus0.image_data = d; bus0.image_data_enable = en;
        bus1.interrupt = irq; bus1.virtual_channel = vc; bus1.word_count = wc;
        bus1.image_data_type = dt; bus1.image_data = d; bus1.image_data_enable = en;
    endtask

    task automatic step(input logic irq, input logic [1:0] vc, input logic [15:0] wc,
                        input logic [5:0] dt, input logic [31:0] d, input logic en);
        drive(irq, vc, wc, dt, d, en);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_in_frame[k] = 0; m_fnum[k] = '0; m_lines[k] = 0;
            m_long[k] = 0; m_rem[k] = 0; m_pdt[k] = '0; m_ign[k] = 0;
        end
    endtask

    task automatic clear_pulses();
        e_fs = 0; e_fe = 0; e_ep = 0; e_el = 0; e_pv = 0; e_pl = 0;
        e_pd = '0; e_pk = '0;
    endtask

    task automatic check_cycle(input int k, input string tag);
        obs_t o;
        string t;
        o = get_obs(k);
        t = $sformatf("%s_d%0d", tag, k);
        check({t, "_fa"}, 32'(o.fa), 32'(m_in_frame[k]));
        check({t, "_fs"}, 32'(o.fs), 32'(e_fs));
        check({t, "_fe"}, 32'(o.fe), 32'(e_fe));
        check({t, "_ep"}, 32'(o.ep), 32'(e_ep));
        check({t, "_el"}, 32'(o.el), 32'(e_el));
        check({t, "_pv"}, 32'(o.pv), 32'(e_pv));
        check({t, "_pl"}, 32'(o.pl), 32'(e_pl));
        check({t, "_fn"}, 32'(o.fn), 32'(m_fnum[k]));
        check({t, "_lc"}, 32'(o.lc), 32'(m_lines[k]));
        if (e_pv) begin
            check({t, "_pd"}, o.pd, e_pd);
            check({t, "_pk"}, 32'(o.pk), 32'(e_pk));
        end
        if (m_long[k]) check({t, "_pdt"}, 32'(o.pdt), 32'(m_pdt[k]));
    endtask

    task automatic check_all_zero(input string tag);
        obs_t o;
        for (int k = 0; k < 2; k++) begin
            o = get_obs(k);
            check($sformatf("%s_d%0d_flags", tag, k),
                  {20'd0, o.fa, o.fs, o.fe, o.pv, o.pl, o.ep, o.el, 5'd0}, 32'd0);
            check($sformatf("%s_d%0d_fn", tag, k), 32'(o.fn), 32'd0);
            check($sformatf("%s_d%0d_lc", tag, k), 32'(o.lc), 32'd0);
            check($sformatf("%s_d%0d_pd", tag, k), o.pd, 32'd0);
            check($sformatf("%s_d%0d_pk", tag, k), 32'(o.pk), 32'd0);
            check($sformatf("%s_d%0d_pdt", tag, k), 32'(o.pdt), 32'd0);
        end
    endtask

    task automatic model_header(input int k, input logic [1:0] vc, input logic [5:0] dt,
                                input logic [15:0] wc);
        bit acc;
        acc = (k == 1) || (vc == 2'd0);
        m_ign[k] = !acc;
        if (!acc) return;
        if (dt == DT_FS) begin
            e_ep = m_in_frame[k]; e_fs = 1;
            m_in_frame[k] = 1; m_fnum[k] = wc; m_lines[k] = 0;
        end else if (dt == DT_FE) begin
            if (m_in_frame[k]) begin
                e_fe = 1; e_ep = (wc != m_fnum[k]); m_in_frame[k] = 0;
            end else begin
                e_ep = 1;
            end
        end else if (dt >= DT_LONG_MIN) begin
            if (m_in_frame[k]) begin
                m_long[k] = 1; m_rem[k] = int'(wc); m_pdt[k] = dt;
            end else begin
                e_ep = 1;
            end
        end else if (dt == DT_LS || dt == DT_LE) begin
            e_ep = !m_in_frame[k];
        end
    endtask

    task automatic model_beat(input int k, input logic [31:0] d);
        if (m_ign[k] || !m_long[k]) return;
        if (m_rem[k] == 0) begin
            e_el = 1;
        end else begin
            e_pv = 1; e_pd = d;
            e_pk = (m_rem[k] >= 4) ? 4'hF : 4'((1 << m_rem[k]) - 1);
            m_rem[k] = m_rem[k] - ((m_rem[k] >= 4) ? 4 : m_rem[k]);
            e_pl = (m_rem[k] == 0);
        end
    endtask

    task automatic model_end(input int k);
        if (m_ign[k]) begin
            m_ign[k] = 0;
            return;
        end
        if (m_long[k]) begin
            e_el = (m_rem[k] != 0);
            m_lines[k] = (m_lines[k] < LINE_MAX) ? m_lines[k] + 1 : LINE_MAX;
            m_long[k] = 0;
        end
    endtask

    task automatic pkt_header(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
        step(1'b1, vc, wc, dt, 32'd0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            clear_pulses(); model_header(k, vc, dt, wc); check_cycle(k, "hdr");
        end
    endtask

    task automatic pkt_beat(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
        logic [31:0] d;
        d = (pay.size() != 0) ? pay.pop_front() : $urandom;
        step(1'b1, vc, wc, dt, d, 1'b1);
        for (int k = 0; k < 2; k++) begin
            clear_pulses(); model_beat(k, d); check_cycle(k, "beat");
        end
    endtask

    task automatic pkt_end(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
        step(1'b0, vc, wc, dt, 32'd0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            clear_pulses(); model_end(k); check_cycle(k, "end");
        end
    endtask

    task automatic send_pkt(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                            input int nbeats);
        if (dt == DT_FS) last_fs_wc = wc;
        pkt_header(vc, dt, wc);
        for (int b = 0; b < nbeats; b++) pkt_beat(vc, dt, wc);
        pkt_end(vc, dt, wc);
    endtask

    initial begin
        drive(1'b0, 2'd0, 16'd0, 6'd0, 32'd0, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        rst_n = 1'b1;
        step(1'b0, 2'd0, 16'd0, 6'd0, 32'd0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            clear_pulses(); check_cycle(k, "idle");
        end

        // Basic frame, long packets of exact and short length, overrun beat
        send_pkt(2'd0, DT_FS, 16'h0007, 0);
        pay.push_back(32'hFEE1DEAD);
        pay.push_back(32'h0D15EA5E);
        send_pkt(2'd0, 6'h18, 16'd8, 2);
        send_pkt(2'd0, 6'h2A, 16'd6, 3);
        send_pkt(2'd0, 6'h2B, 16'd7, 1);
        send_pkt(2'd0, DT_LS, 16'd1, 0);
        send_pkt(2'd0, DT_FE, 16'h0007, 0);

        // Errors while idle
        send_pkt(2'd0, DT_FE, 16'h0003, 0);
        send_pkt(2'd0, 6'h1E, 16'd8, 2);
        send_pkt(2'd0, DT_LE, 16'd0, 1);

        // VC filter, FS restart, FE frame-number mismatch
        send_pkt(2'd1, DT_FS, 16'h0055, 0);
        send_pkt(2'd0, DT_FS, 16'h0005, 0);
        send_pkt(2'd0, DT_FS, 16'h0009, 0);
        send_pkt(2'd1, 6'h24, 16'd4, 1);
        send_pkt(2'd0, DT_FE, 16'h000A, 0);

        // Zero-length lines and line counter saturation
        send_pkt(2'd0, DT_FS, 16'h0100, 0);
        for (int i = 0; i < LINE_MAX + 2; i++) send_pkt(2'd0, 6'h2C, 16'd0, 0);
        send_pkt(2'd0, DT_FE, 16'h0100, 0);

        // Reset mid long packet, with the interrupt still asserted across release
        send_pkt(2'd0, DT_FS, 16'h0042, 0);
        pkt_header(2'd0, 6'h2B, 16'd8);
        pkt_beat(2'd0, 6'h2B, 16'd8);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        pkt_beat(2'd0, 6'h2B, 16'd8);
        pkt_end(2'd0, 6'h2B, 16'd8);

        // Randomized packet stream
        for (int i = 0; i < 250; i++) begin
            logic [1:0]  vc;
            logic [5:0]  dt;
            logic [15:0] wc;
            int          nb;
            int          sel;
            vc  = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'd0;
            sel = $urandom_range(0, 9);
            nb  = 0;
            if (sel <= 1) begin
                dt = DT_FS; wc = 16'($urandom_range(0, 65535));
            end else if (sel == 2) begin
                dt = DT_FE;
                wc = ($urandom_range(0, 3) != 0) ? last_fs_wc : 16'($urandom_range(0, 65535));
            end else if (sel == 3) begin
                dt = 6'($urandom_range(2, 3)); wc = 16'($urandom_range(0, 65535));
                nb = $urandom_range(0, 1);
            end else if (sel == 4) begin
                dt = 6'($urandom_range(8, 15)); wc = 16'($urandom_range(0, 65535));
            end else begin
                dt = 6'($urandom_range(16, 63)); wc = 16'($urandom_range(0, 14));
                nb = (int'(wc) + 3) / 4 + $urandom_range(0, 2) - 1;
                if (nb < 0) nb = 0;
            end
            send_pkt(vc, dt, wc, nb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/csi2_frame_controller.md
Name: csi2_frame_controller

Overview:
Sequences the parsed packet stream from the CSI-2 `camera` receiver into frame/line/pixel events.
- Tracks frame state from Frame Start/End short packets and counts lines.
- Gates long-packet payload beats into a byte-qualified pixel stream, using the packet word count to mark valid bytes.
- Flags protocol and length errors.
- Sits directly after `camera` and ahead of the pixel unpacker/framebuffer writer.

Parameters:
VC_SELECT, 0, virtual channel accepted; packets on other VCs are ignored entirely.
ACCEPT_ALL_VC, 0, when 1 the VC filter is disabled.
LINE_W, 12, width of line_count; the counter saturates at 2^LINE_W-1.

Ports:
clock  in  1  single system clock (the `camera` output clock domain).
reset_n  in  1  asynchronous, active-low reset.
virtual_channel  in  2  header VC from camera.
word_count  in  16  header word count (long packet) or short-packet data field.
image_data_type  in  6  header data type.
image_data  in  32  payload beat; byte 0 = bits 7:0 = first byte on the wire.
image_data_enable  in  1  payload beat valid.
interrupt  in  1  high from header-valid until packet end.
frame_active  out  1  high between an accepted FS and FE.
frame_start  out  1  one-cycle pulse on an accepted FS.
frame_end  out  1  one-cycle pulse on an accepted FE.
frame_number  out  16  word_count captured from the last FS.
line_count  out  LINE_W  long packets completed in the current frame.
pixel_data  out  32  registered payload beat.
pixel_keep  out  4  valid-byte mask for pixel_data.
pixel_valid  out  1  pixel_data/pixel_keep valid.
pixel_last  out  1  last beat of the packet (remaining bytes reached 0).
pixel_data_type  out  6  data type of the current long packet.
err_protocol  out  1  one-cycle pulse on a sequence violation.
err_length  out  1  one-cycle pulse on a payload/word-count mismatch.

Behaviour:
- Reset: every output is 0, state is IDLE, internal counters are 0. Reset is asynchronous and may occur mid-packet; no pulse is emitted on release.
- Header event: the cycle in which interrupt is 1 and its registered copy is 0. Header fields are sampled in that cycle.
  - A header failing the VC filter sets an internal ignore flag until interrupt falls. The whole packet then has no effect.
- Packet end: interrupt is 0 and its registered copy is 1.
- Outputs are registered. Each output appears one cycle after the input event that causes it.
- States: IDLE, FRAME, LONG, DROP.
- Header event, FS (0x00):
  - IDLE -> FRAME.
  - Pulse frame_start, set frame_number = word_count, line_count = 0.
  - In FRAME, also pulse err_protocol and restart the frame (same updates).
- Header event, FE (0x01):
  - FRAME -> IDLE, pulse frame_end.
  - If word_count != frame_number, also pulse err_protocol.
  - In IDLE: pulse err_protocol, stay in IDLE.
- Header event, LS/LE (0x02/0x03) and generic short (0x08-0x0F): no state change. LS/LE received in IDLE pulse err_protocol.
- Header event, long packet (data type >= 0x10):
  - FRAME -> LONG; set remaining = word_count, capture pixel_data_type.
  - IDLE -> DROP; pulse err_protocol.
- LONG, on each image_data_enable:
  - pixel_valid = 1, pixel_data = image_data.
  - pixel_keep = 4'b1111 if remaining >= 4, else (1<<remaining)-1.
  - remaining -= min(4, remaining).
  - pixel_last = 1 when the new remaining is 0.
  - A beat arriving with remaining already 0 is not forwarded and pulses err_length.
- LONG, on packet end:
  - If remaining != 0, pulse err_length.
  - line_count increments (saturating); state -> FRAME.
  - A word_count = 0 packet emits no beats but still increments line_count.
- DROP: beats are discarded; packet end -> IDLE.
- A header event in the same cycle as a packet end: the end is processed first, then the header.
- image_data_enable outside LONG/DROP is ignored, with no error.

Decomposition:
- Add to the shared package csi2_pkg:
  - data-type constants DT_FS=6'h00, DT_FE=6'h01, DT_LS=6'h02, DT_LE=6'h03, DT_LONG_MIN=6'h10;
  - state enum frame_state_t {IDLE, FRAME, LONG, DROP}.
- No sub-module. The keep-mask computation is a local function in the package.

Test Plan:
1. FS with wc=0x0007, then FE with wc=0x0007 on VC0 -> frame_start pulse, frame_number=0x0007, frame_active 1 then 0, frame_end pulse, no errors.
2. FS, then a long packet (dt 0x18, wc=8, payload 0xFEE1DEAD, 0x0D15EA5E), then FE -> two beats with keep 4'hF/4'hF, pixel_last on the 2nd beat, pixel_data_type=0x18, line_count=1.
3. Long packet wc=6 inside a frame -> beat1 keep 4'hF, beat2 keep 4'h3 with pixel_last; a 3rd beat injected -> err_length pulse and that beat is not forwarded.
4. FE or long packet while IDLE -> err_protocol pulse, no pixel_valid, state stays IDLE.
5. FS on VC1 with VC_SELECT=0 -> no frame_start, frame_active stays 0; the same stimulus with ACCEPT_ALL_VC=1 -> frame_start pulse.
6. Assert reset_n low for one cycle mid long packet (after 1 of 2 beats) -> all outputs 0 immediately, state IDLE; after release, remaining beats are ignored with no error.
